// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/bubble control for the 5-stage pipeline (HOLD/RUN/MEM_WAIT FSM).
// Optional PIPE_CTRL_PERF_EN adds stall_cnt_o/flush_cnt_o performance counters.
module pipe_ctrl #(
  parameter int RST_HOLD_CYCLES = 2,
  parameter int MEM_TIMEOUT     = 255
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [4:0] D_rs1_i,
  input  logic [4:0] D_rs2_i,
  input  logic       D_use_rs1_i,
  input  logic       D_use_rs2_i,
  input  logic [6:0] E_opcode_i,
  input  logic [4:0] E_rd_i,
  input  logic       e_Cnd_i,
  input  logic       M_mem_req_i,
  input  logic       dmem_ready_i,
  output logic       F_stall_o,
  output logic       F_bubble_o,
  output logic       D_stall_o,
  output logic       D_bubble_o,
  output logic       E_stall_o,
  output logic       E_bubble_o,
  output logic       M_stall_o,
  output logic       W_bubble_o,
  output logic [1:0] state_o,
  output logic       mem_err_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  typedef enum logic [1:0] {S_HOLD = 2'b00, S_RUN = 2'b01, S_WAIT = 2'b10} state_e;
  state_e      state_q;
  logic [3:0]  hold_cnt_q;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        err_q, hold, redirect, load_use, mem_wait, stall, flush, lu;
  assign redirect = (E_opcode_i == OP_JAL) | (E_opcode_i == OP_JALR) | e_Cnd_i;
  assign load_use = (E_opcode_i == OP_LOAD) & (E_rd_i != 5'd0) &
                    ((D_use_rs1_i & (D_rs1_i == E_rd_i)) | (D_use_rs2_i & (D_rs2_i == E_rd_i)));
  assign mem_wait = M_mem_req_i & ~dmem_ready_i;
  // Reset is folded in so the outputs show HOLD values before the first edge too
  assign hold  = ~rst_n_i | (state_q == S_HOLD);
  assign stall = ~hold & mem_wait;
  assign flush = ~hold & ~mem_wait & redirect;
  assign lu    = ~hold & ~mem_wait & ~redirect & load_use;
  assign F_stall_o  = stall | lu;
  assign F_bubble_o = hold;
  assign D_stall_o  = stall | lu;
  assign D_bubble_o = hold | flush;
  assign E_stall_o  = stall;
  assign E_bubble_o = hold | flush | lu;
  assign M_stall_o  = stall;
  assign W_bubble_o = hold | stall;
  assign state_o    = rst_n_i ? state_q : S_HOLD;
  assign mem_err_o  = rst_n_i & err_q;
  assign wait_cnt_d = &wait_cnt_q ? wait_cnt_q : wait_cnt_q + 16'd1;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_HOLD;
      hold_cnt_q <= 4'(RST_HOLD_CYCLES - 1);
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (hold_cnt_q == 4'd0) state_q <= S_RUN;
          else hold_cnt_q <= hold_cnt_q - 4'd1;
        end
        S_RUN: begin
          wait_cnt_q <= '0;
          if (mem_wait) state_q <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt_q <= wait_cnt_d;
          if (wait_cnt_d == 16'(MEM_TIMEOUT)) err_q <= 1'b1;
          if (dmem_ready_i) state_q <= S_RUN;
        end
        default: state_q <= S_HOLD;
      endcase
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (F_stall_o) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors for pipe_ctrl with hand-computed stage-control patterns.
// ctl packs {F_stall,F_bubble,D_stall,D_bubble,E_stall,E_bubble,M_stall,W_bubble}.
module tb_pipe_ctrl;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;
  localparam logic [7:0] C_HOLD = 8'h55, C_FLUSH = 8'h14, C_LU = 8'hA4, C_MW = 8'hAB;
  logic       clk_i = 1'b0, rst_n_i;
  logic [4:0] D_rs1_i, D_rs2_i, E_rd_i;
  logic       D_use_rs1_i, D_use_rs2_i, e_Cnd_i, M_mem_req_i, dmem_ready_i;
  logic [6:0] E_opcode_i;
  logic       F_stall_o, F_bubble_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o, M_stall_o, W_bubble_o;
  logic [1:0] state_o;
  logic       mem_err_o;
  logic [7:0] ctl;
  int         n_checks = 0, n_errors = 0;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif
  pipe_ctrl #(.RST_HOLD_CYCLES(2), .MEM_TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .D_rs1_i(D_rs1_i), .D_rs2_i(D_rs2_i), .D_use_rs1_i(D_use_rs1_i), .D_use_rs2_i(D_use_rs2_i),
    .E_opcode_i(E_opcode_i), .E_rd_i(E_rd_i), .e_Cnd_i(e_Cnd_i),
    .M_mem_req_i(M_mem_req_i), .dmem_ready_i(dmem_ready_i),
    .F_stall_o(F_stall_o), .F_bubble_o(F_bubble_o), .D_stall_o(D_stall_o), .D_bubble_o(D_bubble_o),
    .E_stall_o(E_stall_o), .E_bubble_o(E_bubble_o), .M_stall_o(M_stall_o), .W_bubble_o(W_bubble_o),
    .state_o(state_o), .mem_err_o(mem_err_o)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  assign ctl = {F_stall_o, F_bubble_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o, M_stall_o, W_bubble_o};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic expect_out(input string tag, input logic [7:0] c, input logic [1:0] s, input logic e);
    #2;
    check({tag, ".ctl"}, 32'(ctl), 32'(c));
    check({tag, ".state"}, 32'(state_o), 32'(s));
    check({tag, ".err"}, 32'(mem_err_o), 32'(e));
  endtask
  initial begin
    rst_n_i = 1'b0; D_rs1_i = '0; D_rs2_i = '0; E_rd_i = '0; D_use_rs1_i = 1'b0; D_use_rs2_i = 1'b0;
    e_Cnd_i = 1'b0; M_mem_req_i = 1'b0; dmem_ready_i = 1'b0; E_opcode_i = OP_ALU;
    step(); step();
    expect_out("rst", C_HOLD, 2'b00, 1'b0);
    step(); rst_n_i = 1'b1;
    expect_out("hold1", C_HOLD, 2'b00, 1'b0);
    step(); expect_out("hold2", C_HOLD, 2'b00, 1'b0);
    step(); expect_out("run", 8'h00, 2'b01, 1'b0);
    step(); e_Cnd_i = 1'b1;
    expect_out("br_taken", C_FLUSH, 2'b01, 1'b0);
    step(); e_Cnd_i = 1'b0;
    expect_out("br_done", 8'h00, 2'b01, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
    check("flush_cnt", flush_cnt_o, 32'd1);
`endif
    step(); E_opcode_i = OP_JAL;
    expect_out("jal", C_FLUSH, 2'b01, 1'b0);
    step(); E_opcode_i = OP_JALR;
    expect_out("jalr", C_FLUSH, 2'b01, 1'b0);
    step(); E_opcode_i = OP_LOAD; E_rd_i = 5'd5; D_rs1_i = 5'd5; D_use_rs1_i = 1'b1;
    expect_out("lu_rs1", C_LU, 2'b01, 1'b0);
    step(); E_rd_i = 5'd0; D_rs1_i = 5'd0;
    expect_out("lu_x0", 8'h00, 2'b01, 1'b0);
    step(); E_rd_i = 5'd9; D_rs1_i = 5'd1; D_rs2_i = 5'd9; D_use_rs2_i = 1'b0;
    expect_out("lu_rs2_unused", 8'h00, 2'b01, 1'b0);
    step(); D_use_rs2_i = 1'b1;
    expect_out("lu_rs2", C_LU, 2'b01, 1'b0);
    step(); E_opcode_i = OP_ALU;
    expect_out("alu_nohaz", 8'h00, 2'b01, 1'b0);
    step(); M_mem_req_i = 1'b1; dmem_ready_i = 1'b0;
    expect_out("mw0", C_MW, 2'b01, 1'b0);
    step(); expect_out("mw1", C_MW, 2'b10, 1'b0);
    step(); expect_out("mw2", C_MW, 2'b10, 1'b0);
    step(); dmem_ready_i = 1'b1;
    expect_out("mw_rdy", 8'h00, 2'b10, 1'b0);
    step(); expect_out("mw_hit", 8'h00, 2'b01, 1'b0);
    step(); dmem_ready_i = 1'b0; E_opcode_i = OP_JAL;
    expect_out("wj0", C_MW, 2'b01, 1'b0);
    step(); expect_out("wj1", C_MW, 2'b10, 1'b0);
    step(); dmem_ready_i = 1'b1;
    expect_out("wj_rdy", C_FLUSH, 2'b10, 1'b0);
    step(); M_mem_req_i = 1'b0; dmem_ready_i = 1'b0; E_opcode_i = OP_ALU;
    expect_out("wj_done", 8'h00, 2'b01, 1'b0);
    step(); M_mem_req_i = 1'b1;
    expect_out("to_run", C_MW, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); expect_out("to_wait", C_MW, 2'b10, 1'b0);
    end
    step(); expect_out("to_err", C_MW, 2'b10, 1'b1);
    step(); expect_out("to_stick", C_MW, 2'b10, 1'b1);
    step(); rst_n_i = 1'b0;
    expect_out("to_rst", C_HOLD, 2'b00, 1'b0);
    step(); rst_n_i = 1'b1; M_mem_req_i = 1'b0;
    expect_out("re_hold1", C_HOLD, 2'b00, 1'b0);
    step(); expect_out("re_hold2", C_HOLD, 2'b00, 1'b0);
    step(); expect_out("re_run", 8'h00, 2'b01, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
